neuron_ctrl: RTL and testbench
==============================

Name: neuron_ctrl

Overview:
- FSM controller that sequences the single-neuron MAC datapath: x/w memory reads, operand register loads, accumulator enable/clear, activation ready and result register write.
- Processes NUM_IN input vectors of DIM elements each against one weight vector selected at start.
- Produces one activated result per input vector.
- Sits between the top-level start/done handshake and the datapath's control inputs.

Parameters:
- Q, 4, address width of x/w memories (addr_x, addr_w, w_sel, result_idx).
- d, 3, dimension index width (index_d_x, index_d_w).
- DIM, 8, elements per vector; 1 <= DIM <= 2**d.
- NUM_IN, 4, input vectors per run; 1 <= NUM_IN <= 2**Q.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin run; sampled only in IDLE.
- abort  in  1  synchronous cancel of a run in progress.
- w_sel  in  Q  weight vector address; latched when start is accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of a run.
- result_valid  out  1  one-cycle pulse; datapath data_out holds result result_idx.
- result_idx  out  Q  input vector index of the current result.
- memRead_x, memRead_w  out  1  memory read strobes.
- addr_x, addr_w  out  Q  memory addresses.
- index_d_x, index_d_w  out  d  element index.
- x_write, w_write  out  1  operand register loads.
- acc_en  out  1  accumulate.
- clear_acc  out  1  zero the accumulator.
- ready  out  1  activation function enable.
- res_write  out  1  result register load.

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; every output 0; counters 0. Applies mid-run and takes priority over abort and start.
- States: IDLE, CLEAR, FETCH, LOAD, MAC, ACT, STORE, DONE. Outputs are Moore (decoded from state and registers).
- IDLE: if start=1, latch w_sel, set vec_cnt=0 and el_cnt=0, go to CLEAR. Otherwise stay.
- CLEAR: clear_acc=1 for 1 cycle, then FETCH.
- FETCH: memRead_x=memRead_w=1, addr_x=vec_cnt, addr_w=latched w_sel, index_d_x=index_d_w=el_cnt. Go to LOAD.
- LOAD: x_write=w_write=1; memory output is valid 1 cycle after the read. Address and index outputs are held. Go to MAC.
- MAC: acc_en=1.
  - If el_cnt==DIM-1: el_cnt=0, go to ACT.
  - Else: el_cnt++, go to FETCH.
- ACT: ready=1, then STORE.
- STORE: res_write=1 and ready=1 (activation output must stay valid while the result register is written).
  - If vec_cnt==NUM_IN-1: go to DONE.
  - Else: vec_cnt++, go to CLEAR.
- result_valid is a registered pulse in the cycle after each STORE, with result_idx = vec_cnt of that STORE.
- DONE: done=1 for 1 cycle, then IDLE.
  - The final result_valid coincides with done.
- Address and index outputs read 0 in IDLE. Outside FETCH/LOAD they hold their last value.
- Latency:
  - Per vector: 3*DIM+3 cycles (CLEAR + DIM*(FETCH,LOAD,MAC) + ACT + STORE).
  - done is asserted NUM_IN*(3*DIM+3)+1 cycles after the start-accept edge.
- Boundaries:
  - start while busy is ignored.
  - start in the DONE cycle is ignored; a new run needs start in IDLE.
  - abort=1 in any non-IDLE state: next state IDLE, no done, no result_valid for the partial vector, and all strobes 0 from the next cycle.
  - abort in IDLE has no effect.
  - DIM=1: the loop exits on the first MAC.
  - NUM_IN=1: a single vector, then DONE.
  - Counters never wrap: they stop at DIM-1 and NUM_IN-1.

Optional Feature:
- Macro NEURON_CTRL_PERF_EN.
- Defined:
  - Adds output cycle_cnt (32 bits): counts clk edges while busy=1.
  - Cleared on rst and on start accept; holds its value after done or abort.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package neuron_pkg:
  - state enum (IDLE..DONE, 3-bit encoding);
  - constant CYCLES_PER_ELEM=3;
  - constant CYCLES_OVERHEAD=3.
- One sub-module, neuron_ctrl_cnt: a parameterised up-counter with clear, enable and terminal-count flag, instantiated for el_cnt (width d) and vec_cnt (width Q).

Test Plan:
- Test parameters: DIM=8, NUM_IN=4.
- Basic run: reset, then start with w_sel=5 -> busy next cycle; addr_w==5 in every FETCH; 4 result_valid pulses with result_idx 0,1,2,3, spaced 27 cycles apart; done exactly 109 cycles after the start edge, then IDLE.
- Strobe order per element: check FETCH, then LOAD, then MAC strobes on consecutive cycles, with index_d 0..7 in order. Expect exactly 8 acc_en pulses between each clear_acc and the following ready.
- Start while busy: pulse start at cycle 10 of a run -> ignored; done still at 109; only 4 results.
- Abort: assert abort during MAC of vector 2, element 3 -> IDLE next cycle; all strobes 0; no done; only 2 result_valid pulses (idx 0,1).
- Reset mid-run: rst=1 during the LOAD of vector 1 -> all outputs 0 after the edge; a new start completes a normal full run.
- With NEURON_CTRL_PERF_EN defined: cycle_cnt==109 after a full run; cycle_cnt holds its value at the abort point after an abort.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and timing constants for the single-neuron MAC controller.
package neuron_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FETCH = 3'd2,
    LOAD  = 3'd3,
    MAC   = 3'd4,
    ACT   = 3'd5,
    STORE = 3'd6,
    DONE  = 3'd7
  } state_t;

  localparam int CYCLES_PER_ELEM = 3;
  localparam int CYCLES_OVERHEAD = 3;

  // Start-accept edge to the cycle in which done is high.
  function automatic int run_latency(input int dim, input int num_in);
    return num_in * (CYCLES_PER_ELEM * dim + CYCLES_OVERHEAD) + 1;
  endfunction

endpackage

// File: rtl/neuron_ctrl_cnt.sv
// Saturating up-counter with synchronous clear, enable and terminal-count flag.
module neuron_ctrl_cnt #(
  parameter int W   = 4,
  parameter int MAX = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  assign tc = (count == MAX_V);

  // Stops at MAX rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/neuron_ctrl.sv
// Sequencer for the single-neuron MAC datapath: NUM_IN vectors x DIM elements.
// Optional cycle_cnt performance counter enabled by NEURON_CTRL_PERF_EN.
module neuron_ctrl
  import neuron_pkg::*;
#(
  parameter int Q      = 4,
  parameter int d      = 3,
  parameter int DIM    = 8,
  parameter int NUM_IN = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [Q-1:0] w_sel,
  output logic         busy,
  output logic         done,
  output logic         result_valid,
  output logic [Q-1:0] result_idx,
  output logic         memRead_x,
  output logic         memRead_w,
  output logic [Q-1:0] addr_x,
  output logic [Q-1:0] addr_w,
  output logic [d-1:0] index_d_x,
  output logic [d-1:0] index_d_w,
  output logic         x_write,
  output logic         w_write,
  output logic         acc_en,
  output logic         clear_acc,
  output logic         ready,
  output logic         res_write,
  output logic [2:0]   dbg_state
`ifdef NEURON_CTRL_PERF_EN
  ,
  output logic [31:0]  cycle_cnt
`endif
);

  state_t       state, state_nxt;
  logic         start_acc, abort_run;
  logic [d-1:0] el_cnt;
  logic [Q-1:0] vec_cnt;
  logic         el_tc, vec_tc;
  logic [Q-1:0] wsel_r, ax_r, aw_r;
  logic [d-1:0] idx_r;

  assign start_acc = (state == IDLE) && start;
  assign abort_run = (state != IDLE) && abort;
  assign dbg_state = state;

  neuron_ctrl_cnt #(.W(d), .MAX(DIM-1)) u_el_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_acc || abort_run || (state == MAC && el_tc)),
    .en    (state == MAC),
    .count (el_cnt),
    .tc    (el_tc)
  );

  neuron_ctrl_cnt #(.W(Q), .MAX(NUM_IN-1)) u_vec_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_acc || abort_run),
    .en    (state == STORE),
    .count (vec_cnt),
    .tc    (vec_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort_run) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = CLEAR;
        CLEAR:   state_nxt = FETCH;
        FETCH:   state_nxt = LOAD;
        LOAD:    state_nxt = MAC;
        MAC:     state_nxt = el_tc ? ACT : FETCH;
        ACT:     state_nxt = STORE;
        STORE:   state_nxt = vec_tc ? DONE : CLEAR;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Address/index shadow registers keep the last FETCH value until the next run.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) begin
      ax_r  <= '0;
      aw_r  <= '0;
      idx_r <= '0;
    end else if (state == FETCH) begin
      ax_r  <= vec_cnt;
      aw_r  <= wsel_r;
      idx_r <= el_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wsel_r       <= '0;
      result_valid <= 1'b0;
      result_idx   <= '0;
    end else begin
      if (start_acc) wsel_r <= w_sel;
      result_valid <= (state == STORE) && !abort;
      if (state == STORE && !abort) result_idx <= vec_cnt;
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = 1'b0;
    memRead_x = 1'b0;
    memRead_w = 1'b0;
    x_write   = 1'b0;
    w_write   = 1'b0;
    acc_en    = 1'b0;
    clear_acc = 1'b0;
    ready     = 1'b0;
    res_write = 1'b0;
    addr_x    = ax_r;
    addr_w    = aw_r;
    index_d_x = idx_r;
    index_d_w = idx_r;
    case (state)
      IDLE: begin
        addr_x    = '0;
        addr_w    = '0;
        index_d_x = '0;
        index_d_w = '0;
      end
      CLEAR: clear_acc = 1'b1;
      FETCH: begin
        memRead_x = 1'b1;
        memRead_w = 1'b1;
        addr_x    = vec_cnt;
        addr_w    = wsel_r;
        index_d_x = el_cnt;
        index_d_w = el_cnt;
      end
      LOAD: begin
        x_write = 1'b1;
        w_write = 1'b1;
      end
      MAC:   acc_en = 1'b1;
      ACT:   ready = 1'b1;
      STORE: begin
        ready     = 1'b1;
        res_write = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

`ifdef NEURON_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || start_acc) cycle_cnt <= '0;
    else if (busy)        cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_neuron_ctrl.sv
// Directed bench for neuron_ctrl: cycle-timed strobe model plus result scoreboard.
module tb_neuron_ctrl;

  localparam int Q       = 4;
  localparam int D       = 3;
  localparam int DIM     = 8;
  localparam int NUM_IN  = 4;
  localparam int PER_VEC = 3 * DIM + 3;
  localparam int RUN     = NUM_IN * PER_VEC + 1;

  logic         clk = 1'b0;
  logic         rst, start, abort;
  logic [Q-1:0] w_sel;
  logic         busy, done, result_valid;
  logic [Q-1:0] result_idx, addr_x, addr_w;
  logic         memRead_x, memRead_w, x_write, w_write;
  logic         acc_en, clear_acc, ready, res_write;
  logic [D-1:0] index_d_x, index_d_w;
  logic [2:0]   dbg_state;
`ifdef NEURON_CTRL_PERF_EN
  logic [31:0]  cycle_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [Q-1:0] m_ridx;
  logic [Q-1:0] exp_q[$];

  neuron_ctrl #(.Q(Q), .d(D), .DIM(DIM), .NUM_IN(NUM_IN)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .w_sel        (w_sel),
    .busy         (busy),
    .done         (done),
    .result_valid (result_valid),
    .result_idx   (result_idx),
    .memRead_x    (memRead_x),
    .memRead_w    (memRead_w),
    .addr_x       (addr_x),
    .addr_w       (addr_w),
    .index_d_x    (index_d_x),
    .index_d_w    (index_d_w),
    .x_write      (x_write),
    .w_write      (w_write),
    .acc_en       (acc_en),
    .clear_acc    (clear_acc),
    .ready        (ready),
    .res_write    (res_write),
    .dbg_state    (dbg_state)
`ifdef NEURON_CTRL_PERF_EN
    ,
    .cycle_cnt    (cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One run from IDLE: start accepted on the first edge, then ncyc sampled cycles.
  // start_k/abort_k/rst_k: cycle whose negedge drives that input high (0 = never).
  task automatic do_run(input logic [Q-1:0] wsel, input int ncyc, input int start_k,
                        input int abort_k, input int rst_k, input int exp_cc,
                        input int exp_done, input int exp_nres);
    int stop_k = 0;
    int done_k = 0;
    int n_done = 0;
    int n_rv   = 0;
    int acc_cnt = 0;
    int m_lv = 0, m_le = 0, m_lw = 0;
    exp_q.delete();
    for (int v = 0; v < exp_nres; v++) exp_q.push_back(Q'(v));
    @(negedge clk);
    start = 1'b1;
    w_sel = wsel;
    for (int k = 1; k <= ncyc; k++) begin
      logic active;
      logic e_busy, e_done, e_rv, e_mr, e_ld, e_acc, e_clr, e_rdy, e_rw;
      int p, v;
      @(negedge clk);
      if (k == 1) w_sel = ~wsel;
      active = !(stop_k != 0 && k > stop_k) && (k <= RUN);
      {e_busy, e_done, e_rv, e_mr, e_ld, e_acc, e_clr, e_rdy, e_rw} = '0;
      if (active) begin
        e_busy = 1'b1;
        if (k == RUN) begin
          e_done = 1'b1;
          e_rv   = 1'b1;
          m_ridx = Q'(NUM_IN - 1);
        end else begin
          p = (k - 1) % PER_VEC;
          v = (k - 1) / PER_VEC;
          if (p == 0) begin
            e_clr = 1'b1;
            if (v > 0) begin
              e_rv   = 1'b1;
              m_ridx = Q'(v - 1);
            end
          end else if (p <= 3 * DIM) begin
            case ((p - 1) % 3)
              0: begin
                e_mr = 1'b1;
                m_lv = v;
                m_le = (p - 1) / 3;
                m_lw = int'(wsel);
              end
              1: e_ld = 1'b1;
              default: e_acc = 1'b1;
            endcase
          end else if (p == 3 * DIM + 1) begin
            e_rdy = 1'b1;
          end else begin
            e_rdy = 1'b1;
            e_rw  = 1'b1;
          end
        end
      end
      check("strobes",
            {busy, done, result_valid, memRead_x, memRead_w, x_write, w_write,
             acc_en, clear_acc, ready, res_write},
            {e_busy, e_done, e_rv, e_mr, e_mr, e_ld, e_ld, e_acc, e_clr, e_rdy, e_rw});
      check("addr_x",    addr_x,    active ? m_lv : 0);
      check("addr_w",    addr_w,    active ? m_lw : 0);
      check("index_d_x", index_d_x, active ? m_le : 0);
      check("index_d_w", index_d_w, active ? m_le : 0);
      check("result_idx", result_idx, m_ridx);
      if (clear_acc) acc_cnt = 0;
      if (acc_en) acc_cnt++;
      if (res_write) check("acc_per_vec", acc_cnt, DIM);
      if (done) begin
        n_done++;
        done_k = k;
      end
      if (result_valid) begin
        n_rv++;
        if (exp_q.size() > 0) check("result_sb", result_idx, exp_q.pop_front());
      end
      start = (k == start_k);
      abort = (k == abort_k);
      rst   = (k == rst_k);
      if (k == abort_k || k == rst_k) stop_k = k;
      if (k == rst_k) m_ridx = '0;
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    check("done_count", n_done, exp_done);
    if (exp_done != 0) check("done_cycle", done_k, RUN);
    check("result_count", n_rv, exp_nres);
    check("sb_left", exp_q.size(), 0);
`ifdef NEURON_CTRL_PERF_EN
    check("cycle_cnt", cycle_cnt, exp_cc);
`else
    if (exp_cc < 0) $display("unexpected negative cycle budget");
`endif
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    w_sel = '0;
    m_ridx = '0;
    repeat (3) @(negedge clk);
    check("reset_strobes",
          {busy, done, result_valid, memRead_x, memRead_w, x_write, w_write,
           acc_en, clear_acc, ready, res_write}, 0);
    check("reset_addr", {addr_x, addr_w, index_d_x, index_d_w, result_idx}, 0);
    check("reset_state", dbg_state, 0);
    rst   = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    check("abort_idle_busy", busy, 0);
    abort = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Basic run; start pulsed in the DONE cycle must be ignored.
    do_run(4'd5, RUN + 3, RUN, 0, 0, RUN, 1, NUM_IN);
    // start at cycle 10 while busy is ignored.
    do_run(4'd9, RUN + 2, 10, 0, 0, RUN, 1, NUM_IN);
    // Abort during MAC of vector 2, element 3.
    do_run(4'd3, 80, 0, 2 * PER_VEC + 13, 0, 2 * PER_VEC + 13, 0, 2);
    // Reset during LOAD of vector 1, element 0.
    do_run(4'd7, 35, 0, 0, PER_VEC + 3, 0, 0, 1);
    // Normal run after the mid-run reset.
    do_run(4'd12, RUN + 1, 0, 0, 0, RUN, 1, NUM_IN);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
